mtm_alu_result_deserializer: RTL and testbench
==============================================

// Module: mtm_alu_result_deserializer
// PURPOSE
//  Receive end of the ALU result serial link: decodes the 1-bit-per-clk
//  frame stream produced by the ALU output serializer and rebuilds the
//  32-bit result C and the 8-bit CTL byte.
//  Used on the result path of a chained block and as the bench-side monitor.
//  Raises a one-cycle strobe per complete packet and flags line/protocol errors.
// PARAMETERS
//  DATA_BYTES    4   data frames expected before the CTL frame in a normal packet
//  GAP_TIMEOUT  16   max idle cycles (sin=1) allowed between frames of one packet; 0 = disabled
// PORTS
//  clk        in   1   clock; one serial bit per rising edge, no oversampling
//  rst_n      in   1   synchronous reset, active-low
//  sin        in   1   serial line; idles high
//  c_out      out  32  received result, first data byte = c_out[31:24]
//  ctl_out    out  8   received CTL byte
//  rx_valid   out  1   one-cycle strobe: c_out/ctl_out updated with a new packet
//  rx_err     out  1   one-cycle strobe: packet aborted
//  err_code   out  2   valid with rx_err: 01 framing, 10 protocol, 11 gap timeout
// BEHAVIOUR
//  Reset: c_out=0, ctl_out=0, rx_valid=0, rx_err=0, err_code=0, FSM=IDLE,
//   byte count=0, buffers cleared. Reset mid-frame discards all partial data.
//  Frame (11 bits, 1 per clk): start 0 | type (0=data,1=ctl) | 8 bits MSB first | stop 1.
//  FSM: IDLE -sin=0-> TYPE -> DATA (8 cycles, bit_cnt 0..7) -> STOP -> IDLE.
//   IDLE: sin=1 holds; counts gap cycles only when byte_cnt!=0.
//   TYPE: latch type bit. DATA: shift sin into 8-bit shift reg, MSB first.
//   STOP: evaluate frame; next cycle is IDLE (back-to-back start accepted there).
//  At STOP, sin=0: framing error (01); partial packet dropped, byte_cnt=0.
//  At STOP, sin=1, type=data:
//   byte_cnt<DATA_BYTES: byte -> C buffer (buffer<<8 | byte), byte_cnt++.
//   byte_cnt==DATA_BYTES: protocol error (10); drop, byte_cnt=0.
//  At STOP, sin=1, type=ctl:
//   byte_cnt==DATA_BYTES and ctl[7]=0: c_out<=C buffer, ctl_out<=ctl, rx_valid.
//   byte_cnt==0 and ctl[7]=1: error-only packet; c_out<=0, ctl_out<=ctl, rx_valid.
//   any other combination: protocol error (10); outputs unchanged.
//   byte_cnt=0 afterwards in every case.
//  Latency: rx_valid/rx_err high in the cycle after the clock edge that
//   samples the final stop bit; c_out/ctl_out hold until next rx_valid.
//  Gap timeout: byte_cnt!=0 and GAP_TIMEOUT consecutive IDLE cycles with
//   sin=1 -> error (11), byte_cnt=0. Counter clears on every start bit.
//  rx_valid and rx_err never assert together. Errors never alter c_out/ctl_out.
//  Counters: bit_cnt 3b, byte_cnt 3b (saturation impossible: cleared on overflow
//   error), gap counter sized clog2(GAP_TIMEOUT+1).
// TESTING
//  1) Serialize C=32'hDEADBEEF, CTL=8'h4A (4 data + ctl frames, back-to-back)
//     -> one rx_valid, c_out=DEADBEEF, ctl_out=4A, no rx_err.
//  2) Single ctl frame 8'hC9 -> rx_valid, c_out=0, ctl_out=C9.
//  3) Stop bit forced 0 on 2nd data frame -> rx_err, err_code=01; following
//     good packet 32'h00000001/8'h02 received correctly.
//  4) 3 data frames then ctl 8'h10 -> rx_err, err_code=10; 5 data frames -> err 10
//     at 5th stop bit.
//  5) 2 data frames, then sin=1 for 16 cycles -> rx_err, err_code=11; with 15
//     idle cycles and remaining frames -> valid packet.
//  6) rst_n low during 3rd data frame, released, full packet sent -> only new
//     packet reported; all outputs 0 during reset.

Source files
------------

// File: rtl/mtm_alu_result_deserializer_if.sv
// Serial result link between the ALU serializer and its receiver.
// master drives the line; slave decodes it and reports packets.
interface mtm_alu_result_deserializer_if;
    logic        sin;
    logic [31:0] c_out;
    logic [7:0]  ctl_out;
    logic        rx_valid;
    logic        rx_err;
    logic [1:0]  err_code;

    modport master (
        output sin,
        input  c_out, ctl_out, rx_valid, rx_err, err_code
    );

    modport slave (
        input  sin,
        output c_out, ctl_out, rx_valid, rx_err, err_code
    );
endinterface

// File: rtl/mtm_alu_result_deserializer.sv
// Receive end of the ALU result serial link: rebuilds C and CTL from
// 11-bit frames and strobes valid/error once per packet.
module mtm_alu_result_deserializer #(
    parameter int DATA_BYTES  = 4,
    parameter int GAP_TIMEOUT = 16
) (
    input logic clk,
    input logic rst_n,
    mtm_alu_result_deserializer_if.slave rx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TYPE = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] STOP = 2'd3;

    localparam int GW = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0);
    localparam logic [2:0] NB = 3'(DATA_BYTES);

    localparam logic [1:0] E_FRAME = 2'b01;
    localparam logic [1:0] E_PROTO = 2'b10;
    localparam logic [1:0] E_GAP   = 2'b11;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_cnt;
    logic          type_q;
    logic [7:0]    sh;
    logic [31:0]   c_buf;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   c_q;
    logic [7:0]    ctl_q;
    logic          valid_q;
    logic          err_q;
    logic [1:0]    code_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            type_q   <= 1'b0;
            sh       <= '0;
            c_buf    <= '0;
            gap_cnt  <= '0;
            c_q      <= '0;
            ctl_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            unique case (state)
                IDLE: begin
                    if (!rx.sin) begin
                        state   <= TYPE;
                        gap_cnt <= '0;
                    end else if (byte_cnt != 3'd0 && GAP_TIMEOUT > 0) begin
                        // idle line while a packet is half-received
                        if (gap_cnt == GAP_LAST) begin
                            err_q    <= 1'b1;
                            code_q   <= E_GAP;
                            byte_cnt <= '0;
                            c_buf    <= '0;
                            gap_cnt  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                TYPE: begin
                    type_q  <= rx.sin;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    sh      <= {sh[6:0], rx.sin};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7)
                        state <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                    if (!rx.sin) begin
                        err_q    <= 1'b1;
                        code_q   <= E_FRAME;
                        byte_cnt <= '0;
                        c_buf    <= '0;
                    end else if (!type_q) begin
                        if (byte_cnt < NB) begin
                            c_buf    <= {c_buf[23:0], sh};
                            byte_cnt <= byte_cnt + 1'b1;
                        end else begin
                            err_q    <= 1'b1;
                            code_q   <= E_PROTO;
                            byte_cnt <= '0;
                            c_buf    <= '0;
                        end
                    end else begin
                        byte_cnt <= '0;
                        c_buf    <= '0;
                        if (byte_cnt == NB && !sh[7]) begin
                            c_q     <= c_buf;
                            ctl_q   <= sh;
                            valid_q <= 1'b1;
                        end else if (byte_cnt == 3'd0 && sh[7]) begin
                            c_q     <= '0;
                            ctl_q   <= sh;
                            valid_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= E_PROTO;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.c_out    = c_q;
    assign rx.ctl_out  = ctl_q;
    assign rx.rx_valid = valid_q;
    assign rx.rx_err   = err_q;
    assign rx.err_code = code_q;

endmodule

// File: tb/tb_mtm_alu_result_deserializer.sv
// Bench for the result deserializer: frame-level reference model,
// directed scenarios plus randomized packet traffic.
module tb_mtm_alu_result_deserializer;

    localparam int GT = 16;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mtm_alu_result_deserializer_if bus ();

    mtm_alu_result_deserializer #(
        .DATA_BYTES(NB),
        .GAP_TIMEOUT(GT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  kind;
        logic [31:0] c;
        logic [7:0]  ctl;
        logic [1:0]  code;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    logic [7:0] m_bytes[$];
    logic [31:0] m_c;
    logic [7:0]  m_ctl;
    int m_idle;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.rx_valid || bus.rx_err) begin
            ev_t e;
            e.cyc  = cyc;
            e.kind = {bus.rx_valid, bus.rx_err};
            e.c    = bus.c_out;
            e.ctl  = bus.ctl_out;
            e.code = bus.err_code;
            obs_q.push_back(e);
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        n_chk++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: got %h, want %h", tag, obs, want);
    endtask

    task automatic send_bit(logic b);
        @(negedge clk);
        bus.sin = b;
    endtask

    // kind: 2'b10 = packet strobe, 2'b01 = error strobe
    task automatic push_exp(logic [1:0] kind, logic [1:0] code);
        ev_t e;
        e.cyc  = cyc + 1;
        e.kind = kind;
        e.c    = m_c;
        e.ctl  = m_ctl;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic frame(logic typ, logic [7:0] b, logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(stop);
        m_idle = 0;
        if (!stop) begin
            m_bytes.delete();
            push_exp(2'b01, 2'b01);
        end else if (!typ) begin
            if (m_bytes.size() < NB) begin
                m_bytes.push_back(b);
            end else begin
                m_bytes.delete();
                push_exp(2'b01, 2'b10);
            end
        end else begin
            if (m_bytes.size() == NB && !b[7]) begin
                m_c   = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                m_ctl = b;
                push_exp(2'b10, 2'b00);
            end else if (m_bytes.size() == 0 && b[7]) begin
                m_c   = 32'h0;
                m_ctl = b;
                push_exp(2'b10, 2'b00);
            end else begin
                push_exp(2'b01, 2'b10);
            end
            m_bytes.delete();
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b1);
            m_idle++;
            if (m_idle == GT && m_bytes.size() != 0) begin
                m_bytes.delete();
                push_exp(2'b01, 2'b11);
            end
        end
    endtask

    task automatic packet(logic [31:0] c, logic [7:0] ctl);
        for (int i = 3; i >= 0; i--) frame(1'b0, c[i*8 +: 8], 1'b1);
        frame(1'b1, ctl, 1'b1);
    endtask

    task automatic check_outputs_zero(string tag);
        chk({tag, " c_out"}, bus.c_out, 32'h0);
        chk({tag, " ctl_out"}, {24'h0, bus.ctl_out}, 32'h0);
        chk({tag, " rx_valid"}, {31'h0, bus.rx_valid}, 32'h0);
        chk({tag, " rx_err"}, {31'h0, bus.rx_err}, 32'h0);
        chk({tag, " err_code"}, {30'h0, bus.err_code}, 32'h0);
    endtask

    task automatic check_events(string tag);
        int n;
        idle(20);
        chk({tag, " count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s ev%0d cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s ev%0d kind", tag, i),
                {30'h0, obs_q[i].kind}, {30'h0, exp_q[i].kind});
            chk($sformatf("%s ev%0d c", tag, i), obs_q[i].c, exp_q[i].c);
            chk($sformatf("%s ev%0d ctl", tag, i),
                {24'h0, obs_q[i].ctl}, {24'h0, exp_q[i].ctl});
            if (exp_q[i].kind == 2'b01)
                chk($sformatf("%s ev%0d code", tag, i),
                    {30'h0, obs_q[i].code}, {30'h0, exp_q[i].code});
        end
        chk({tag, " hold c"}, bus.c_out, m_c);
        chk({tag, " hold ctl"}, {24'h0, bus.ctl_out}, {24'h0, m_ctl});
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.sin = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero(tag);
        rst_n = 1'b1;
        m_bytes.delete();
        m_c    = 32'h0;
        m_ctl  = 8'h0;
        m_idle = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic rframe(logic typ, logic [7:0] b);
        int g;
        logic stop;
        g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18))
                                        : int'($urandom_range(0, 2));
        stop = ($urandom_range(0, 24) != 0);
        idle(g);
        frame(typ, b, stop);
    endtask

    initial begin
        int r;
        int k;
        logic [31:0] rc;
        bus.sin = 1'b1;
        m_c = 32'h0;
        m_ctl = 8'h0;
        m_idle = 0;

        do_reset("reset");

        packet(32'hDEADBEEF, 8'h4A);
        check_events("s1 packet");

        frame(1'b1, 8'hC9, 1'b1);
        check_events("s2 err-only");

        frame(1'b0, 8'hDE, 1'b1);
        frame(1'b0, 8'hAD, 1'b0);
        packet(32'h00000001, 8'h02);
        check_events("s3 framing");

        for (int i = 0; i < 3; i++) frame(1'b0, 8'h11 * i, 1'b1);
        frame(1'b1, 8'h10, 1'b1);
        check_events("s4 short");
        for (int i = 0; i < 5; i++) frame(1'b0, 8'h5A + i, 1'b1);
        check_events("s4 long");

        frame(1'b0, 8'hA1, 1'b1);
        frame(1'b0, 8'hA2, 1'b1);
        idle(16);
        check_events("s5 timeout");
        frame(1'b0, 8'h12, 1'b1);
        frame(1'b0, 8'h34, 1'b1);
        idle(15);
        frame(1'b0, 8'h56, 1'b1);
        frame(1'b0, 8'h78, 1'b1);
        frame(1'b1, 8'h3C, 1'b1);
        check_events("s5 gap15");

        frame(1'b0, 8'hF0, 1'b1);
        frame(1'b0, 8'hF1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        do_reset("s6 midreset");
        packet(32'hCAFEF00D, 8'h21);
        check_events("s6 after");

        for (int p = 0; p < 40; p++) begin
            r  = int'($urandom_range(0, 9));
            rc = $urandom;
            if (r < 7) begin
                for (int i = 3; i >= 0; i--) rframe(1'b0, rc[i*8 +: 8]);
                rframe(1'b1, 8'($urandom) & 8'h7F);
            end else if (r == 7) begin
                rframe(1'b1, 8'($urandom) | 8'h80);
            end else if (r == 8) begin
                k = int'($urandom_range(1, 5));
                for (int i = 0; i < k; i++) rframe(1'b0, 8'($urandom));
                rframe(1'b1, 8'($urandom));
            end else begin
                idle(int'($urandom_range(0, 3)));
                frame(1'b0, 8'($urandom), 1'b0);
            end
        end
        check_events("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
